// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding an 8-deep FWFT FIFO; a byte is visible the cycle after its stop sample.
// No backpressure on rx itself: rts asks the host to pause, and bytes arriving while the FIFO is full are dropped and flagged in overrun.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT  = 64,
    parameter int DEPTH_LOG2    = 3,
    parameter int RTS_THRESHOLD = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  rts,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    output logic                  frame_err,
    input  logic                  clr_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int BCW   = $clog2(CLKS_PER_BIT);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] HALF_LAST = BCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0]  RTS_TH    = CW'(RTS_THRESHOLD);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE} state_t;
`endif

    state_t                 state_q;
    logic                   rx_meta_q, rx_sync_q;
    logic                   armed_q;
    logic [BCW-1:0]         baud_q;
    logic [2:0]             bit_idx_q;
    logic [7:0]             shift_q;
    logic                   frame_err_q;
    logic                   baud_done, push;

    logic [7:0]             mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q, count_d;
    logic                   overrun_q, overrun_d, rts_q;
    logic                   do_push, do_pop;

    // Synchronizer resets low so a line must actually be seen high before arming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b0;
            rx_sync_q <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign baud_done = (baud_q == BIT_LAST);
    assign push      = (state_q == S_STOP) && baud_done && rx_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            armed_q     <= 1'b0;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    baud_q <= '0;
                    if (rx_sync_q)
                        armed_q <= 1'b1;
                    else if (armed_q)
                        state_q <= S_START;
                end
                S_START: begin
                    if (baud_q == HALF_LAST) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_sync_q ? S_IDLE : S_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud_q    <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (bit_idx_q == 3'd7) state_q <= S_PARITY;
`else
                        if (bit_idx_q == 3'd7) state_q <= S_STOP;
`endif
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (rx_sync_q ^ (^shift_q)) begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_WAIT_IDLE;
                        end else begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        // Good stop returns half a bit early so a back-to-back start edge is not missed.
                        if (rx_sync_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_WAIT_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx_sync_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    always_comb begin
        do_pop    = rd_en && (count_q != '0);
        do_push   = push && ((count_q != FULL_CNT) || do_pop);
        count_d   = count_q;
        if (do_push && !do_pop)
            count_d = count_q + CW'(1);
        else if (!do_push && do_pop)
            count_d = count_q - CW'(1);
        overrun_d = overrun_q;
        if (push && !do_push)
            overrun_d = 1'b1;
        else if (clr_err)
            overrun_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            rts_q     <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            rts_q     <= (count_q >= RTS_TH);
        end
    end

    assign rd_data   = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign rts       = rts_q;

endmodule
